// File: rtl/wb_rr_arbiter_wdog.sv
// Round-robin WISHBONE arbiter for the SURF register intercon, with a bus-timeout
// watchdog that forces a one-cycle error and logs the culprit when no slave answers.
module wb_rr_arbiter_wdog #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 22,
  parameter int TIMEOUT     = 1023,
  parameter int CNT_WIDTH   = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [NUM_MASTERS-1:0] cyc_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  input  logic                   stb_i,
  input  logic [ADDR_WIDTH-1:0]  adr_i,
  input  logic                   ack_i,
  input  logic                   err_i,
  input  logic                   rty_i,
  output logic                   tmo_err_o,
  output logic [15:0]            tmo_count_o,
  output logic [ADDR_WIDTH-1:0]  tmo_adr_o,
  output logic [2:0]             tmo_master_o,
  input  logic                   clr_i
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANTED = 2'd1;
  localparam logic [1:0] ST_TMO     = 2'd2;

  localparam bit                   WD_EN    = (TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] WD_LAST  = CNT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [2:0]           LAST_RST = 3'(NUM_MASTERS - 1);

  // First asserted request at last+1, last+2, ... (mod NUM_MASTERS); the
  // descending scan lets the nearest successor overwrite farther ones.
  function automatic logic [2:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                         input logic [2:0]             last);
    int idx;
    rr_pick = last;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      for (int j = 0; j < NUM_MASTERS; j++)
        if (j == idx && req[j]) rr_pick = 3'(j);
    end
  endfunction

  // Saturating event counter; a clear coinciding with an event leaves exactly one.
  function automatic logic [15:0] cnt_next(input logic [15:0] cnt,
                                           input logic        inc,
                                           input logic        clr);
    if (clr)                          cnt_next = inc ? 16'd1 : 16'd0;
    else if (inc && cnt != 16'hFFFF)  cnt_next = cnt + 16'd1;
    else                              cnt_next = cnt;
  endfunction

  logic [1:0]             state_q, state_d;
  logic [2:0]             last_q, last_d, pick;
  logic [CNT_WIDTH-1:0]   wd_q, wd_d;
  logic [NUM_MASTERS-1:0] gnt_d, pick_oh;
  logic                   term, cur_cyc, expire;

  assign term    = ack_i | err_i | rty_i;
  assign cur_cyc = |(cyc_i & gnt_o);
  assign pick    = rr_pick(cyc_i, last_q);
  assign pick_oh = NUM_MASTERS'(1) << pick;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_o;
    last_d  = last_q;
    wd_d    = '0;
    expire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|cyc_i) begin
          gnt_d   = pick_oh;
          last_d  = pick;
          state_d = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        if (!cur_cyc) begin
          // Handover without an idle bubble when someone else is waiting.
          if (|cyc_i) begin
            gnt_d  = pick_oh;
            last_d = pick;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else if (stb_i && !term) begin
          if (WD_EN && wd_q == WD_LAST) begin
            expire  = 1'b1;
            state_d = ST_TMO;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      ST_TMO:  state_d = ST_GRANTED;
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      gnt_o        <= '0;
      last_q       <= LAST_RST;
      wd_q         <= '0;
      tmo_err_o    <= 1'b0;
      tmo_count_o  <= 16'd0;
      tmo_adr_o    <= '0;
      tmo_master_o <= 3'd0;
    end else begin
      state_q     <= state_d;
      gnt_o       <= gnt_d;
      last_q      <= last_d;
      wd_q        <= wd_d;
      tmo_err_o   <= expire;
      tmo_count_o <= cnt_next(tmo_count_o, expire, clr_i);
      if (expire) begin
        tmo_adr_o    <= adr_i;
        tmo_master_o <= last_q;
      end
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter_wdog.sv
// Directed bench for wb_rr_arbiter_wdog: default-size instance plus short-timeout
// and watchdog-disabled instances for counter clear, saturation and TIMEOUT=0.
module tb_wb_rr_arbiter_wdog;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cyc, gnt, tmo_master;
  logic        stb, ack, err, rty, clr, tmo_err;
  logic [21:0] adr, tmo_adr;
  logic [15:0] tmo_count;

  logic [2:0]  s_cyc, s_gnt, s_master, z_gnt, z_master;
  logic        s_stb, s_ack, s_err, s_rty, s_clr, s_tmo_err, z_tmo_err;
  logic [21:0] s_adr, s_tmo_adr, z_tmo_adr;
  logic [15:0] s_cnt, z_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int s_c;
  logic [15:0] s_cnt_m;

  always #5 clk = ~clk;

  wb_rr_arbiter_wdog dut (
    .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc), .gnt_o(gnt), .stb_i(stb), .adr_i(adr),
    .ack_i(ack), .err_i(err), .rty_i(rty), .tmo_err_o(tmo_err), .tmo_count_o(tmo_count),
    .tmo_adr_o(tmo_adr), .tmo_master_o(tmo_master), .clr_i(clr));

  wb_rr_arbiter_wdog #(.NUM_MASTERS(3), .ADDR_WIDTH(22), .TIMEOUT(4), .CNT_WIDTH(3)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .cyc_i(s_cyc), .gnt_o(s_gnt), .stb_i(s_stb), .adr_i(s_adr),
    .ack_i(s_ack), .err_i(s_err), .rty_i(s_rty), .tmo_err_o(s_tmo_err), .tmo_count_o(s_cnt),
    .tmo_adr_o(s_tmo_adr), .tmo_master_o(s_master), .clr_i(s_clr));

  wb_rr_arbiter_wdog #(.NUM_MASTERS(3), .ADDR_WIDTH(22), .TIMEOUT(0), .CNT_WIDTH(3)) dut_z (
    .clk_i(clk), .rst_n_i(rst_n), .cyc_i(s_cyc), .gnt_o(z_gnt), .stb_i(s_stb), .adr_i(s_adr),
    .ack_i(s_ack), .err_i(s_err), .rty_i(s_rty), .tmo_err_o(z_tmo_err), .tmo_count_o(z_cnt),
    .tmo_adr_o(z_tmo_adr), .tmo_master_o(z_master), .clr_i(s_clr));

  task automatic test_reset;
    rst_n = 1'b0; cyc = '0; stb = 0; adr = '0; ack = 0; err = 0; rty = 0; clr = 0;
    s_cyc = '0; s_stb = 0; s_adr = '0; s_ack = 0; s_err = 0; s_rty = 0; s_clr = 0;
    #1;
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    n_checks++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", tmo_err); end
    n_checks++; if (tmo_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", tmo_count); end
    n_checks++; if (tmo_adr !== 22'd0) begin n_fail++; $display("FAIL reset_adr: got %h expected 0", tmo_adr); end
    n_checks++; if (tmo_master !== 3'd0) begin n_fail++; $display("FAIL reset_master: got %0d expected 0", tmo_master); end
    n_checks++; if (s_cnt !== 16'd0 || z_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_small_count: got %h/%h expected 0", s_cnt, z_cnt); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL idle_gnt: got %b expected 000", gnt); end
  endtask

  task automatic test_single_master;
    cyc = 3'b100;
    @(negedge clk);
    n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL single_grant: got %b expected 100", gnt); end
    cyc = 3'b000;
    @(negedge clk);
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL single_release: got %b expected 000", gnt); end
  endtask

  task automatic test_round_robin;
    int seq [6] = '{0, 1, 2, 0, 1, 2};
    logic [2:0] exp_g;
    cyc = 3'b111;
    for (int i = 0; i < 6; i++) begin
      exp_g = 3'b001 << seq[i];
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n_checks++;
        if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_seq[%0d] cyc %0d: got %b expected %b", i, c, gnt, exp_g); end
        if (c == 0) cyc = 3'b111;
        if (c == 2) cyc = 3'b111 & ~exp_g;
      end
    end
    @(negedge clk);
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL rr_wrap: got %b expected 001", gnt); end
    cyc = 3'b000;
    @(negedge clk);
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rr_idle: got %b expected 000", gnt); end
  endtask

  task automatic test_timeout;
    int bad = 0;
    cyc = 3'b010; adr = 22'h002040;
    @(negedge clk);
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL tmo_grant: got %b expected 010", gnt); end
    stb = 1'b1;
    for (int k = 1; k <= 1022; k++) begin
      @(negedge clk);
      if (tmo_err !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL tmo_early: got %0d error cycles expected 0", bad); end
    @(negedge clk);
    n_checks++; if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse: got %b expected 1", tmo_err); end
    n_checks++; if (tmo_adr !== 22'h002040) begin n_fail++; $display("FAIL tmo_adr: got %h expected 002040", tmo_adr); end
    n_checks++; if (tmo_master !== 3'd1) begin n_fail++; $display("FAIL tmo_master: got %0d expected 1", tmo_master); end
    n_checks++; if (tmo_count !== 16'd1) begin n_fail++; $display("FAIL tmo_count: got %0d expected 1", tmo_count); end
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL tmo_gnt_hold: got %b expected 010", gnt); end
    stb = 1'b0;
    @(negedge clk);
    n_checks++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL tmo_one_cycle: got %b expected 0", tmo_err); end
  endtask

  task automatic test_ack_race;
    int bad = 0;
    @(negedge clk); stb = 1'b1;
    for (int k = 1; k <= 1021; k++) begin
      @(negedge clk);
      if (tmo_err !== 1'b0) bad++;
    end
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0; stb = 1'b0;
    n_checks++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL race_err: got %b expected 0", tmo_err); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL race_early: got %0d error cycles expected 0", bad); end
    @(negedge clk);
    n_checks++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL race_late: got %b expected 0", tmo_err); end
    n_checks++; if (tmo_count !== 16'd1) begin n_fail++; $display("FAIL race_count: got %0d expected 1", tmo_count); end
    cyc = 3'b000;
    @(negedge clk);
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL race_release: got %b expected 000", gnt); end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    cyc = 3'b100;
    @(negedge clk);
    n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL rst_pre_grant: got %b expected 100", gnt); end
    stb = 1'b1;
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rst_async_gnt: got %b expected 000", gnt); end
    n_checks++; if (tmo_count !== 16'd0 || tmo_adr !== 22'd0 || tmo_master !== 3'd0)
      begin n_fail++; $display("FAIL rst_async_log: got %h/%h/%0d expected 0/0/0", tmo_count, tmo_adr, tmo_master); end
    stb = 1'b0; cyc = 3'b111; adr = 22'h1F0F0F;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL rst_first_winner: got %b expected 001", gnt); end
    stb = 1'b1;
    for (int k = 1; k <= 1022; k++) begin
      @(negedge clk);
      if (tmo_err !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rst_wd_cleared: got %0d early error cycles expected 0", bad); end
    @(negedge clk);
    n_checks++; if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL rst_tmo_pulse: got %b expected 1", tmo_err); end
    n_checks++; if (tmo_master !== 3'd0 || tmo_adr !== 22'h1F0F0F || tmo_count !== 16'd1)
      begin n_fail++; $display("FAIL rst_tmo_log: got m%0d a%h c%0d expected m0 a1f0f0f c1", tmo_master, tmo_adr, tmo_count); end
    stb = 1'b0; cyc = 3'b000;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_clr_count;
    logic inc;
    s_cyc = 3'b001; s_adr = 22'h3ABCDE;
    @(negedge clk);
    n_checks++; if (s_gnt !== 3'b001) begin n_fail++; $display("FAIL small_grant: got %b expected 001", s_gnt); end
    s_stb = 1'b1; s_c = 0; s_cnt_m = 16'd0;
    while (s_c < 34) begin
      s_clr = (s_c == 28 || s_c == 31);
      @(negedge clk); s_c++;
      inc = (s_c % 5 == 4);
      if (s_clr) s_cnt_m = inc ? 16'd1 : 16'd0;
      else if (inc && s_cnt_m != 16'hFFFF) s_cnt_m = s_cnt_m + 16'd1;
      n_checks++; if (s_tmo_err !== inc) begin n_fail++; $display("FAIL small_err c%0d: got %b expected %b", s_c, s_tmo_err, inc); end
      n_checks++; if (s_cnt !== s_cnt_m) begin n_fail++; $display("FAIL small_count c%0d: got %0d expected %0d", s_c, s_cnt, s_cnt_m); end
      n_checks++; if (z_tmo_err !== 1'b0 || z_cnt !== 16'd0) begin n_fail++; $display("FAIL wd_disabled c%0d: got %b/%0d expected 0/0", s_c, z_tmo_err, z_cnt); end
      if (inc) begin
        n_checks++; if (s_tmo_adr !== 22'h3ABCDE || s_master !== 3'd0)
          begin n_fail++; $display("FAIL small_log c%0d: got %h/%0d expected 3abcde/0", s_c, s_tmo_adr, s_master); end
      end
      if (s_c == 29) begin
        n_checks++; if (s_cnt !== 16'd1) begin n_fail++; $display("FAIL clr_with_inc: got %0d expected 1", s_cnt); end
      end
    end
    s_clr = 1'b0;
    n_checks++; if (z_gnt !== 3'b001) begin n_fail++; $display("FAIL wd_disabled_gnt: got %b expected 001", z_gnt); end
  endtask

  task automatic test_saturate;
    logic inc;
    force dut_s.tmo_count_o = 16'hFFFD;
    #1 release dut_s.tmo_count_o;
    s_cnt_m = 16'hFFFD;
    while (s_c < 54) begin
      @(negedge clk); s_c++;
      inc = (s_c % 5 == 4);
      if (inc && s_cnt_m != 16'hFFFF) s_cnt_m = s_cnt_m + 16'd1;
      n_checks++; if (s_tmo_err !== inc) begin n_fail++; $display("FAIL sat_err c%0d: got %b expected %b", s_c, s_tmo_err, inc); end
      n_checks++; if (s_cnt !== s_cnt_m) begin n_fail++; $display("FAIL sat_count c%0d: got %h expected %h", s_c, s_cnt, s_cnt_m); end
    end
    n_checks++; if (s_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", s_cnt); end
    s_stb = 1'b0; s_cyc = 3'b000;
    @(negedge clk); @(negedge clk);
    n_checks++; if (s_gnt !== 3'b000) begin n_fail++; $display("FAIL small_release: got %b expected 000", s_gnt); end
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_round_robin();
    test_timeout();
    test_ack_race();
    test_reset_mid();
    test_clr_count();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
